// File: rtl/data_sampler_mv_if.sv
// Serial-sample bus between the RX FSM side (master) and the bit sampler (slave).
// Carries bit-timing inputs from the edge counter and the registered per-bit sample results.
interface data_sampler_mv_if #(
  parameter int PRESCALE_WIDTH = 6
);
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic [PRESCALE_WIDTH-1:0] edge_cnt;
  logic                      dat_samp_en;
  logic                      rx_in;
  logic                      sampled_bit;
  logic                      sample_valid;
  logic                      noise_flag;
  logic                      prescale_err;

  modport master (
    output prescale, edge_cnt, dat_samp_en, rx_in,
    input  sampled_bit, sample_valid, noise_flag, prescale_err
  );

  modport slave (
    input  prescale, edge_cnt, dat_samp_en, rx_in,
    output sampled_bit, sample_valid, noise_flag, prescale_err
  );
endinterface

// File: rtl/data_sampler_mv.sv
// UART RX bit sampler: oversamples rx around the bit centre, optional 2-of-3 vote, noise flag.
// Result/strobe registered one cycle after the last sample point; no backpressure, strobe is fire-and-forget.
module data_sampler_mv #(
  parameter int PRESCALE_WIDTH = 6,
  parameter int SYNC_STAGES    = 2,
  parameter int MAJORITY       = 1
) (
  input  logic             clk,
  input  logic             reset,
  data_sampler_mv_if.slave bus
);
  typedef logic [PRESCALE_WIDTH-1:0] cnt_t;
  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t     state_q;
  logic [1:0] count_q;
  logic [1:0] samp_q;
  logic       sampled_bit_q;
  logic       sample_valid_q;
  logic       noise_flag_q;
  logic       prescale_err_q;

  logic rx_s;
  cnt_t mid;
  cnt_t pt_first;
  cnt_t pt_next;
  logic err_d;
  logic start_hit;
  logic collect_hit;
  logic rearm_d;
  logic vote_d;
  logic noise_d;

  // The upstream edge counter is aligned to the synchronised line, not the raw pin.
  if (SYNC_STAGES == 0) begin : g_direct
    assign rx_s = bus.rx_in;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q;
    always_ff @(posedge clk) begin
      if (reset) begin
        sync_q <= '1;
      end else begin
        sync_q[0] <= bus.rx_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
          sync_q[i] <= sync_q[i-1];
        end
      end
    end
    assign rx_s = sync_q[SYNC_STAGES-1];
  end

  always_comb begin
    err_d = bus.prescale[0];
    if (MAJORITY != 0) begin
      err_d = err_d | (bus.prescale < cnt_t'(4));
    end else begin
      err_d = err_d | (bus.prescale < cnt_t'(2));
    end
  end

  assign mid         = (bus.prescale >> 1) - cnt_t'(1);
  assign pt_first    = (MAJORITY != 0) ? mid - cnt_t'(1) : mid;
  assign pt_next     = pt_first + cnt_t'(count_q);
  assign start_hit   = bus.dat_samp_en && (bus.edge_cnt == pt_first);
  assign collect_hit = (bus.edge_cnt == pt_next);

  // The third sample is voted straight from the line, never stored.
  always_comb begin
    if (MAJORITY != 0) begin
      vote_d  = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
      noise_d = !((samp_q[0] == samp_q[1]) && (samp_q[1] == rx_s));
    end else begin
      vote_d  = rx_s;
      noise_d = 1'b0;
    end
  end

  // edge_cnt == 0 re-arms in the same cycle so a first point at 0 (prescale 4) is not lost.
  always_comb begin
    rearm_d = 1'b0;
    case (state_q)
      IDLE:    rearm_d = 1'b1;
      COLLECT: rearm_d = bus.dat_samp_en && !collect_hit && (bus.edge_cnt == '0);
      DONE:    rearm_d = bus.dat_samp_en && (bus.edge_cnt == '0);
      default: rearm_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      count_q        <= 2'd0;
      samp_q         <= 2'b00;
      sampled_bit_q  <= 1'b1;
      sample_valid_q <= 1'b0;
      noise_flag_q   <= 1'b0;
      prescale_err_q <= 1'b0;
    end else begin
      prescale_err_q <= err_d;
      sample_valid_q <= 1'b0;
      if (err_d) begin
        state_q <= IDLE;
        count_q <= 2'd0;
      end else if (rearm_d) begin
        if (start_hit) begin
          samp_q[0] <= rx_s;
          if (MAJORITY != 0) begin
            state_q <= COLLECT;
            count_q <= 2'd1;
          end else begin
            sampled_bit_q  <= vote_d;
            noise_flag_q   <= noise_d;
            sample_valid_q <= 1'b1;
            state_q        <= DONE;
            count_q        <= 2'd0;
          end
        end else begin
          state_q <= IDLE;
          count_q <= 2'd0;
        end
      end else if (!bus.dat_samp_en) begin
        state_q <= IDLE;
        count_q <= 2'd0;
      end else if ((state_q == COLLECT) && collect_hit) begin
        if (count_q == 2'd2) begin
          sampled_bit_q  <= vote_d;
          noise_flag_q   <= noise_d;
          sample_valid_q <= 1'b1;
          state_q        <= DONE;
          count_q        <= 2'd0;
        end else begin
          samp_q[count_q[0]] <= rx_s;
          count_q            <= count_q + 2'd1;
        end
      end
    end
  end

  assign bus.sampled_bit  = sampled_bit_q;
  assign bus.sample_valid = sample_valid_q;
  assign bus.noise_flag   = noise_flag_q;
  assign bus.prescale_err = prescale_err_q;
endmodule

// File: tb/tb_data_sampler_mv.sv
// Bench for data_sampler_mv: one majority-vote and one single-sample instance on a shared stimulus stream,
// expectations from a per-bit-period reference model, checked by a scoreboard monitor.
module tb_data_sampler_mv;
  localparam int W    = 6;
  localparam int SYNC = 2;

  typedef struct { int stamp; logic b; logic n; } exp_t;
  typedef struct { logic vld; logic b; logic n; } pred_t;

  logic         clk      = 1'b0;
  logic         rst      = 1'b1;
  logic [W-1:0] ps_drv   = W'(8);
  logic [W-1:0] edge_drv = '0;
  logic         en_drv   = 1'b0;
  logic         rx_drv   = 1'b0;

  always #5 clk = ~clk;

  data_sampler_mv_if #(.PRESCALE_WIDTH(W)) bus1 ();
  data_sampler_mv_if #(.PRESCALE_WIDTH(W)) bus0 ();

  assign bus1.prescale = ps_drv;   assign bus0.prescale = ps_drv;
  assign bus1.edge_cnt = edge_drv; assign bus0.edge_cnt = edge_drv;
  assign bus1.dat_samp_en = en_drv; assign bus0.dat_samp_en = en_drv;
  assign bus1.rx_in = rx_drv;      assign bus0.rx_in = rx_drv;

  data_sampler_mv #(.PRESCALE_WIDTH(W), .SYNC_STAGES(SYNC), .MAJORITY(1)) dut1 (
    .clk(clk), .reset(rst), .bus(bus1)
  );
  data_sampler_mv #(.PRESCALE_WIDTH(W), .SYNC_STAGES(SYNC), .MAJORITY(0)) dut0 (
    .clk(clk), .reset(rst), .bus(bus0)
  );

  int   cyc      = 0;
  logic rst_seen = 1'b0;
  int   ps_seen  = 8;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
    ps_seen  <= int'(ps_drv);
  end

  // Stimulus stream, one entry per clock; s_rxs is the desired synchronised line value.
  int    s_ps[$];
  int    s_edge[$];
  logic  s_en[$];
  logic  s_rxs[$];
  logic  s_rst[$];
  pred_t p1[$];
  pred_t p0[$];

  exp_t q1[$];
  exp_t q0[$];
  exp_t xe;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   n_exp[2] = '{0, 0};
  int   n_seen[2] = '{0, 0};
  logic held[2] = '{1'b1, 1'b1};

  function automatic logic err_of(int maj, int ps);
    return (ps % 2 == 1) || ((maj != 0) ? (ps < 4) : (ps < 2));
  endfunction

  task automatic add_cycle(int ps, int e, logic en, logic rxs, logic r);
    pred_t none;
    none = '{1'b0, 1'b0, 1'b0};
    s_ps.push_back(ps); s_edge.push_back(e); s_en.push_back(en);
    s_rxs.push_back(rxs); s_rst.push_back(r);
    p1.push_back(none); p0.push_back(none);
  endtask

  // A bit votes only if every sample point appears, with enable high, no reset and a legal
  // prescale from the first point through the last one.
  task automatic model_seg(int maj, int start, int len);
    int    ps;
    int    n;
    int    first;
    int    at[3];
    int    ones;
    pred_t pr;
    ps   = s_ps[start];
    n    = (maj != 0) ? 3 : 1;
    ones = 0;
    if (err_of(maj, ps)) return;
    first = ps / 2 - 1 - ((maj != 0) ? 1 : 0);
    for (int k = 0; k < n; k++) begin
      at[k] = -1;
      for (int i = start; i < start + len; i++)
        if (s_edge[i] == first + k) at[k] = i;
      if (at[k] < 0) return;
    end
    for (int i = at[0]; i <= at[n-1]; i++)
      if (!s_en[i] || s_rst[i] || err_of(maj, s_ps[i])) return;
    for (int k = 0; k < n; k++) ones += int'(s_rxs[at[k]]);
    pr.vld = 1'b1;
    pr.b   = (2 * ones > n);
    pr.n   = (ones != 0) && (ones != n);
    if (maj != 0) p1[at[n-1]] = pr;
    else          p0[at[n-1]] = pr;
  endtask

  task automatic add_seg(int ps, logic [63:0] rxv, int drop_e, int skip_e, int rst_e);
    int start;
    start = s_ps.size();
    for (int e = 0; e < ps; e++) begin
      if (e == skip_e) continue;
      add_cycle(ps, e, (drop_e < 0) || (e < drop_e), rxv[e], e == rst_e);
    end
    model_seg(1, start, s_ps.size() - start);
    model_seg(0, start, s_ps.size() - start);
  endtask

  task automatic add_gap(int ps, int n, logic rxs);
    for (int i = 0; i < n; i++) add_cycle(ps, 0, 1'b0, rxs, 1'b0);
  endtask

  task automatic build();
    logic [63:0] ones64;
    logic [63:0] rxv;
    logic [9:0]  pat;
    int          ps_tab[10];
    int          ps;
    int          drop_e;
    int          skip_e;
    int          rst_e;
    ones64 = {64{1'b1}};
    pat    = 10'b1011001110;
    ps_tab = '{4, 6, 8, 10, 12, 16, 20, 2, 3, 7};
    add_cycle(8, 0, 1'b0, 1'b0, 1'b1);
    add_cycle(8, 0, 1'b0, 1'b0, 1'b1);
    add_gap(8, 4, 1'b0);
    add_seg(8, 64'h0, -1, -1, -1);
    for (int i = 0; i < 10; i++) add_seg(16, pat[i] ? ones64 : 64'h0, -1, -1, -1);
    add_seg(16, ~(64'h1 << 7), -1, -1, -1);
    add_seg(16, 64'h0, -1, -1, -1);
    add_seg(16, ones64, 7, -1, -1);
    add_seg(16, ones64, -1, -1, -1);
    add_seg(3, 64'h0, -1, -1, -1);
    add_seg(2, ones64, -1, -1, -1);
    add_seg(4, 64'h0, -1, -1, -1);
    add_seg(4, ones64, -1, -1, -1);
    add_seg(16, 64'h0, -1, -1, 7);
    add_seg(16, ones64, -1, -1, -1);
    add_seg(8, 64'h1 << 3, -1, -1, -1);
    add_seg(8, 64'h0, -1, 3, -1);
    for (int s = 0; s < 200; s++) begin
      ps = ps_tab[$urandom_range(0, 9)];
      case ($urandom_range(0, 3))
        0:       rxv = 64'h0;
        1:       rxv = ones64;
        2:       rxv = {$urandom, $urandom};
        default: rxv = (($urandom_range(0, 1) != 0) ? ones64 : 64'h0) ^ (64'h1 << $urandom_range(0, ps - 1));
      endcase
      drop_e = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, ps - 1)) : -1;
      skip_e = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, ps - 1)) : -1;
      rst_e  = ($urandom_range(0, 24) == 0 && ps >= 6) ? ps - 3 : -1;
      add_seg(ps, rxv, drop_e, skip_e, rst_e);
    end
  endtask

  task automatic cmp_bit(string name, int m, logic act, logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (majority=%0d) cycle %0d: got %b, expected %b", name, m, cyc, act, exp);
    end
  endtask

  task automatic cmp_int(string name, int m, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s (majority=%0d) cycle %0d: got %0d, expected %0d", name, m, cyc, act, exp);
    end
  endtask

  task automatic chk(int m, logic sb, logic v, logic nf, logic pe);
    exp_t x;
    if (rst_seen) begin
      cmp_bit("reset_sampled_bit", m, sb, 1'b1);
      cmp_bit("reset_sample_valid", m, v, 1'b0);
      cmp_bit("reset_noise_flag", m, nf, 1'b0);
      cmp_bit("reset_prescale_err", m, pe, 1'b0);
      held[m] = 1'b1;
    end else begin
      cmp_bit("prescale_err", m, pe, err_of(m, ps_seen));
      if (v === 1'b1) begin
        n_seen[m]++;
        if ((m != 0 && q1.size() == 0) || (m == 0 && q0.size() == 0)) begin
          cmp_int("unexpected_strobe", m, 1, 0);
        end else begin
          x = (m != 0) ? q1.pop_front() : q0.pop_front();
          cmp_int("strobe_cycle", m, cyc, x.stamp);
          cmp_bit("sampled_bit", m, sb, x.b);
          cmp_bit("noise_flag", m, nf, x.n);
          held[m] = x.b;
        end
      end else begin
        cmp_bit("held_bit", m, sb, held[m]);
      end
    end
  endtask

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk(1, bus1.sampled_bit, bus1.sample_valid, bus1.noise_flag, bus1.prescale_err);
      chk(0, bus0.sampled_bit, bus0.sample_valid, bus0.noise_flag, bus0.prescale_err);
    end
  end

  initial begin
    build();
    for (int t = 0; t < s_ps.size(); t++) begin
      @(posedge clk);
      #1;
      ps_drv   = W'(s_ps[t]);
      edge_drv = W'(s_edge[t]);
      en_drv   = s_en[t];
      rst      = s_rst[t];
      rx_drv   = (t + SYNC < s_ps.size()) ? s_rxs[t + SYNC] : 1'b1;
      if (p1[t].vld) begin
        xe = '{cyc + 1, p1[t].b, p1[t].n};
        q1.push_back(xe);
        n_exp[1]++;
      end
      if (p0[t].vld) begin
        xe = '{cyc + 1, p0[t].b, p0[t].n};
        q0.push_back(xe);
        n_exp[0]++;
      end
    end
    @(posedge clk);
    #1;
    en_drv = 1'b0;
    rst    = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    #1;
    cmp_int("strobe_count", 1, n_seen[1], n_exp[1]);
    cmp_int("strobe_count", 0, n_seen[0], n_exp[0]);
    cmp_int("missing_strobes", 1, q1.size(), 0);
    cmp_int("missing_strobes", 0, q0.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
